// File: rtl/sparc_alu_pkg.sv
// Shared definitions for the SPARC ALU sequencer: opcode constants,
// the legal-opcode decode, the icc-update decode and the FSM encoding.
package sparc_alu_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_ADD    = 6'h00;
    localparam logic [OPC_W-1:0] OP_AND    = 6'h01;
    localparam logic [OPC_W-1:0] OP_OR     = 6'h02;
    localparam logic [OPC_W-1:0] OP_XOR    = 6'h03;
    localparam logic [OPC_W-1:0] OP_SUB    = 6'h04;
    localparam logic [OPC_W-1:0] OP_ANDN   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ORN    = 6'h06;
    localparam logic [OPC_W-1:0] OP_XNOR   = 6'h07;
    localparam logic [OPC_W-1:0] OP_ADDX   = 6'h08;
    localparam logic [OPC_W-1:0] OP_SUBX   = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ADDCC  = 6'h10;
    localparam logic [OPC_W-1:0] OP_ANDCC  = 6'h11;
    localparam logic [OPC_W-1:0] OP_ORCC   = 6'h12;
    localparam logic [OPC_W-1:0] OP_XORCC  = 6'h13;
    localparam logic [OPC_W-1:0] OP_SUBCC  = 6'h14;
    localparam logic [OPC_W-1:0] OP_ANDNCC = 6'h15;
    localparam logic [OPC_W-1:0] OP_ORNCC  = 6'h16;
    localparam logic [OPC_W-1:0] OP_XNORCC = 6'h17;
    localparam logic [OPC_W-1:0] OP_ADDXCC = 6'h18;
    localparam logic [OPC_W-1:0] OP_SUBXCC = 6'h1C;
    localparam logic [OPC_W-1:0] OP_SLL    = 6'h25;
    localparam logic [OPC_W-1:0] OP_SRL    = 6'h26;
    localparam logic [OPC_W-1:0] OP_SRA    = 6'h27;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        SAMPLE  = 3'd2,
        MISSUE  = 3'd3,
        MSAMPLE = 3'd4,
        RESP    = 3'd5
    } seq_state_e;

    // Opcodes the ALU implements; anything else completes with an error.
    function automatic logic op_legal(input logic [OPC_W-1:0] op);
        return op inside {[OP_ADD:OP_ADDX], OP_SUBX, [OP_ADDCC:OP_ADDXCC],
                          OP_SUBXCC, [OP_SLL:OP_SRA]};
    endfunction

    // The cc variants (bit 4 set, bit 5 clear) write the icc flags.
    function automatic logic op_sets_icc(input logic [OPC_W-1:0] op);
        return op[4] & ~op[5];
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiply datapath for alu_seq_ctrl. Each step the ALU
// adds the partial sum (hi) and either the multiplicand or zero; the carry,
// sum and low word are then shifted right by one. Compiled only when
// ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_seq_mul
    import sparc_alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            step_en,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_c,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] addend,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next,
    output logic            last
);

    localparam int STEP_W = $clog2(MUL_STEPS);

    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   m;
    logic [STEP_W-1:0] step;

    assign addend  = lo[0] ? m : '0;
    assign hi_next = {alu_c, alu_result[XLEN-1:1]};
    assign lo_next = {alu_result[0], lo[XLEN-1:1]};
    assign last    = (step == STEP_W'(MUL_STEPS - 1));

    // Operand and partial-product registers: loaded on accept, shifted per step.
    always_ff @(posedge clk) begin
        if (load) begin
            hi <= '0;
            lo <= a;
            m  <= b;
        end else if (step_en) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end

    // Step counter, restarted on every multiply accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step <= '0;
        end else if (load) begin
            step <= '0;
        end else if (step_en) begin
            step <= step + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/alu_seq_ctrl.sv
// Sequencer and icc owner for the 32-bit SPARC ALU. Takes one request at a
// time, issues it to the external ALU with an ALUE toggle, samples the result
// a cycle later and holds the response until it is accepted.
// Optional feature macro: ALU_SEQ_MUL_EN adds a 32-step unsigned multiply
// that iterates the ALU adder; without it a multiply request returns an error.
module alu_seq_ctrl
    import sparc_alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OPC_W-1:0] req_opcode,
    input  logic             req_mul,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic [XLEN-1:0]  rsp_hi,
    output logic             rsp_err,
    output logic [OPC_W-1:0] alu_opcode,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic             alu_carry,
    output logic             alu_e,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_c,
    output logic             icc_n,
    output logic             icc_z,
    output logic             icc_v,
    output logic             icc_c
);

    // The multiply needs exactly one shift-add step per operand bit.
    if (XLEN != 32 || MUL_STEPS != XLEN) begin : g_cfg_check
        $error("alu_seq_ctrl: only XLEN = MUL_STEPS = 32 is supported");
    end

    seq_state_e       state;
    logic             accept;
    logic [OPC_W-1:0] op_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;

    assign accept = (state == IDLE) && req_valid && req_ready;

`ifdef ALU_SEQ_MUL_EN
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_addend;
    logic [XLEN-1:0] mul_hi_next;
    logic [XLEN-1:0] mul_lo_next;
    logic            mul_last;

    alu_seq_mul #(
        .XLEN      (XLEN),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk        (clk),
        .reset      (reset),
        .load       (accept && req_mul),
        .a          (req_a),
        .b          (req_b),
        .step_en    (state == MSAMPLE),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .hi         (mul_hi),
        .addend     (mul_addend),
        .hi_next    (mul_hi_next),
        .lo_next    (mul_lo_next),
        .last       (mul_last)
    );
`else
    assign rsp_hi = '0;
`endif

    // Request capture; only the opcode and operands of an ALU op are needed later.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= req_opcode;
            a_q  <= req_a;
            b_q  <= req_b;
        end
    end

    // Sequencer FSM with registered handshake, ALU drive, response and icc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            rsp_hi     <= '0;
`endif
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_carry  <= 1'b0;
            alu_e      <= 1'b0;
            {icc_n, icc_z, icc_v, icc_c} <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready  <= 1'b0;
                        rsp_result <= '0;
                        rsp_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        rsp_hi     <= '0;
`endif
                        if (req_mul) begin
`ifdef ALU_SEQ_MUL_EN
                            state     <= MISSUE;
`else
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
`endif
                        end else if (op_legal(req_opcode)) begin
                            state <= ISSUE;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    alu_opcode <= op_q;
                    alu_a      <= a_q;
                    alu_b      <= b_q;
                    alu_carry  <= icc_c;
                    alu_e      <= ~alu_e;
                    state      <= SAMPLE;
                end
                SAMPLE: begin
                    rsp_result <= alu_result;
                    if (op_sets_icc(op_q)) begin
                        {icc_n, icc_z, icc_v, icc_c} <= {alu_n, alu_z, alu_v, alu_c};
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
`ifdef ALU_SEQ_MUL_EN
                MISSUE: begin
                    alu_opcode <= OP_ADDCC;
                    alu_a      <= mul_hi;
                    alu_b      <= mul_addend;
                    alu_carry  <= 1'b0;
                    alu_e      <= ~alu_e;
                    state      <= MSAMPLE;
                end
                MSAMPLE: begin
                    if (mul_last) begin
                        rsp_result <= mul_lo_next;
                        rsp_hi     <= mul_hi_next;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= MISSUE;
                    end
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
